hpdcache_demux_buf: RTL and testbench

HPDCACHE_DEMUX_BUF -- requirements
Module: hpdcache_demux_buf

---
 rtl/hpdcache_demux_buf_pkg.sv | 16 +
 rtl/hpdcache_demux_buf_fifo.sv | 74 +++++++
 rtl/hpdcache_demux_buf.sv | 87 ++++++++
 tb/tb_hpdcache_demux_buf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_demux_buf_pkg.sv
// Shared helpers for the demultiplexing buffer: select legality check and
// pointer sizing that stays valid for single-entry FIFOs.
package hpdcache_demux_buf_pkg;

    // Selects are widened to this many bits before decoding, so NOUTPUT must not exceed it.
    localparam int unsigned SEL_CMP_W = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic is_one_hot(input logic [SEL_CMP_W-1:0] v);
        return (v != '0) && ((v & (v - 1)) == '0);
    endfunction

endpackage

// File: rtl/hpdcache_demux_buf_fifo.sv
// Per-channel FIFO of DEPTH entries with show-ahead head output, masked to
// zero while empty. Pointers wrap explicitly, so any DEPTH works.
module hpdcache_demux_buf_fifo
    import hpdcache_demux_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned      PTR_W    = ptr_width(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage holds no reset; emptiness masks whatever stale contents remain.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/hpdcache_demux_buf.sv
// Demultiplexer steering one request stream into NOUTPUT independent FIFOs;
// illegal selects are swallowed and flagged with a one-cycle sel_err_o pulse.
module hpdcache_demux_buf
    import hpdcache_demux_buf_pkg::*;
#(
    parameter int unsigned NOUTPUT     = 2,
    parameter int unsigned DATA_WIDTH  = 1,
    parameter int unsigned ONE_HOT_SEL = 0,
    parameter int unsigned DEPTH       = 2,
    localparam int unsigned SEL_WIDTH  = (ONE_HOT_SEL != 0) ? NOUTPUT : $clog2(NOUTPUT)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [SEL_WIDTH-1:0]          sel_i,
    output logic [NOUTPUT-1:0]            valid_o,
    input  logic [NOUTPUT-1:0]            ready_i,
    output logic [NOUTPUT*DATA_WIDTH-1:0] data_o,
    output logic                          sel_err_o
);

    logic [NOUTPUT-1:0] sel_oh;
    logic               sel_legal;
    logic [NOUTPUT-1:0] fifo_full;
    logic [NOUTPUT-1:0] fifo_empty;
    logic [NOUTPUT-1:0] push;
    logic [NOUTPUT-1:0] pop;
    logic               accept;
    logic               sel_err_q, sel_err_d;

    genvar gi;

    generate
        if (ONE_HOT_SEL != 0) begin : g_sel_onehot
            assign sel_oh    = sel_i;
            assign sel_legal = is_one_hot(SEL_CMP_W'(sel_i));
        end else begin : g_sel_binary
            for (gi = 0; gi < NOUTPUT; gi++) begin : g_dec
                assign sel_oh[gi] = (SEL_CMP_W'(sel_i) == gi);
            end
            assign sel_legal = (SEL_CMP_W'(sel_i) < NOUTPUT);
        end
    endgenerate

    // Only the select and registered occupancy feed ready_o, never valid_i or ready_i.
    assign ready_o = !sel_legal || ((sel_oh & fifo_full) == '0);
    assign accept  = valid_i && ready_o;

    generate
        for (gi = 0; gi < NOUTPUT; gi++) begin : g_chan
            assign push[gi]    = accept && sel_legal && sel_oh[gi];
            assign pop[gi]     = ready_i[gi] && !fifo_empty[gi];
            assign valid_o[gi] = !fifo_empty[gi];

            hpdcache_demux_buf_fifo #(
                .DEPTH      (DEPTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .push_i  (push[gi]),
                .data_i  (data_i),
                .pop_i   (pop[gi]),
                .full_o  (fifo_full[gi]),
                .empty_o (fifo_empty[gi]),
                .data_o  (data_o[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        sel_err_d = accept && !sel_legal;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_hpdcache_demux_buf.sv
// Bench for hpdcache_demux_buf: three configurations checked against queue-based
// channel models with directed scenarios and randomized traffic.
module tb_hpdcache_demux_buf;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: NOUTPUT=4, binary select, DEPTH=2
    logic        a_valid_i, a_ready_o, a_sel_err_o;
    logic [7:0]  a_data_i;
    logic [1:0]  a_sel_i;
    logic [3:0]  a_valid_o, a_ready_i;
    logic [31:0] a_data_o;

    // B: NOUTPUT=3, binary select, DEPTH=3
    logic        b_valid_i, b_ready_o, b_sel_err_o;
    logic [7:0]  b_data_i;
    logic [1:0]  b_sel_i;
    logic [2:0]  b_valid_o, b_ready_i;
    logic [23:0] b_data_o;

    // C: NOUTPUT=4, one-hot select, DEPTH=2
    logic        c_valid_i, c_ready_o, c_sel_err_o;
    logic [7:0]  c_data_i;
    logic [3:0]  c_sel_i;
    logic [3:0]  c_valid_o, c_ready_i;
    logic [31:0] c_data_o;

    logic [7:0] mq [4][$];
    logic [7:0] sq [$];

    hpdcache_demux_buf #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(0), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_i(a_data_i), .sel_i(a_sel_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .data_o(a_data_o), .sel_err_o(a_sel_err_o)
    );

    hpdcache_demux_buf #(.NOUTPUT(3), .DATA_WIDTH(8), .ONE_HOT_SEL(0), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_i(b_data_i), .sel_i(b_sel_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .data_o(b_data_o), .sel_err_o(b_sel_err_o)
    );

    hpdcache_demux_buf #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(1), .DEPTH(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid_i), .ready_o(c_ready_o),
        .data_i(c_data_i), .sel_i(c_sel_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .data_o(c_data_o), .sel_err_o(c_sel_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid_i = 0; a_sel_i = 2'd1; a_data_i = 8'h00; a_ready_i = 4'h0;
        b_valid_i = 0; b_sel_i = 2'd0; b_data_i = 8'h00; b_ready_i = 3'h0;
        c_valid_i = 0; c_sel_i = 4'b0001; c_data_i = 8'h00; c_ready_i = 4'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL reset_a_valid: got %b expected %b", a_valid_o, 4'h0); end
        checks++; if (a_data_o !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h expected %h", a_data_o, 32'h0); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_ready_o); end
        checks++; if (a_sel_err_o !== 1'b0) begin errors++; $display("FAIL reset_a_sel_err: got %b expected 0", a_sel_err_o); end
        checks++; if (b_valid_o !== 3'h0) begin errors++; $display("FAIL reset_b_valid: got %b expected %b", b_valid_o, 3'h0); end
        checks++; if (c_valid_o !== 4'h0) begin errors++; $display("FAIL reset_c_valid: got %b expected %b", c_valid_o, 4'h0); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_a_ready: got %b expected 1", a_ready_o); end
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL post_reset_a_valid: got %b expected %b", a_valid_o, 4'h0); end
        $display("test_reset done");
    endtask

    task automatic test_order();
        a_ready_i = 4'h0; a_valid_i = 1; a_sel_i = 2'd2; a_data_i = 8'hA1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL order_ready_first: got %b expected 1", a_ready_o); end
        tick();
        a_data_i = 8'hB2;
        checks++; if (a_valid_o !== 4'b0100) begin errors++; $display("FAIL order_valid_after_a: got %b expected 0100", a_valid_o); end
        checks++; if (a_data_o[23:16] !== 8'hA1) begin errors++; $display("FAIL order_head_a: got %h expected a1", a_data_o[23:16]); end
        tick();
        a_data_i = 8'hC3;
        #1;
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL order_ready_full: got %b expected 0", a_ready_o); end
        checks++; if (a_data_o !== 32'h00A1_0000) begin errors++; $display("FAIL order_data_full: got %h expected 00a10000", a_data_o); end
        tick();
        a_valid_i = 0; a_ready_i = 4'b0100;
        checks++; if (a_data_o[23:16] !== 8'hA1) begin errors++; $display("FAIL order_head_stable: got %h expected a1", a_data_o[23:16]); end
        tick();
        checks++; if (a_data_o[23:16] !== 8'hB2) begin errors++; $display("FAIL order_head_b: got %h expected b2", a_data_o[23:16]); end
        checks++; if (a_valid_o !== 4'b0100) begin errors++; $display("FAIL order_valid_b: got %b expected 0100", a_valid_o); end
        tick();
        a_ready_i = 4'h0;
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL order_drained_valid: got %b expected 0000", a_valid_o); end
        checks++; if (a_data_o !== 32'h0) begin errors++; $display("FAIL order_drained_data: got %h expected 0", a_data_o); end
        $display("test_order done");
    endtask

    task automatic test_illegal_binary();
        b_valid_i = 1; b_sel_i = 2'd3; b_data_i = 8'h55; b_ready_i = 3'h0;
        #1;
        checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_bin_ready: got %b expected 1", b_ready_o); end
        checks++; if (b_sel_err_o !== 1'b0) begin errors++; $display("FAIL illegal_bin_err_early: got %b expected 0", b_sel_err_o); end
        tick();
        b_valid_i = 0;
        checks++; if (b_sel_err_o !== 1'b1) begin errors++; $display("FAIL illegal_bin_err_pulse: got %b expected 1", b_sel_err_o); end
        checks++; if (b_valid_o !== 3'h0) begin errors++; $display("FAIL illegal_bin_valid: got %b expected 000", b_valid_o); end
        tick();
        checks++; if (b_sel_err_o !== 1'b0) begin errors++; $display("FAIL illegal_bin_err_clear: got %b expected 0", b_sel_err_o); end
        checks++; if (b_valid_o !== 3'h0) begin errors++; $display("FAIL illegal_bin_valid_late: got %b expected 000", b_valid_o); end
        $display("test_illegal_binary done");
    endtask

    task automatic test_onehot();
        c_valid_i = 1; c_sel_i = 4'b0110; c_data_i = 8'h11; c_ready_i = 4'h0;
        #1;
        checks++; if (c_ready_o !== 1'b1) begin errors++; $display("FAIL onehot_bad_ready: got %b expected 1", c_ready_o); end
        tick();
        c_sel_i = 4'b1000; c_data_i = 8'h3C;
        checks++; if (c_sel_err_o !== 1'b1) begin errors++; $display("FAIL onehot_bad_err: got %b expected 1", c_sel_err_o); end
        checks++; if (c_valid_o !== 4'h0) begin errors++; $display("FAIL onehot_bad_valid: got %b expected 0000", c_valid_o); end
        tick();
        c_sel_i = 4'b0000; c_data_i = 8'h99;
        checks++; if (c_sel_err_o !== 1'b0) begin errors++; $display("FAIL onehot_good_err: got %b expected 0", c_sel_err_o); end
        checks++; if (c_valid_o !== 4'b1000) begin errors++; $display("FAIL onehot_good_valid: got %b expected 1000", c_valid_o); end
        checks++; if (c_data_o !== 32'h3C00_0000) begin errors++; $display("FAIL onehot_good_data: got %h expected 3c000000", c_data_o); end
        tick();
        c_valid_i = 0; c_ready_i = 4'b1000;
        checks++; if (c_sel_err_o !== 1'b1) begin errors++; $display("FAIL onehot_zero_err: got %b expected 1", c_sel_err_o); end
        checks++; if (c_valid_o !== 4'b1000) begin errors++; $display("FAIL onehot_zero_valid: got %b expected 1000", c_valid_o); end
        tick();
        c_ready_i = 4'h0;
        checks++; if (c_valid_o !== 4'h0) begin errors++; $display("FAIL onehot_pop_valid: got %b expected 0000", c_valid_o); end
        $display("test_onehot done");
    endtask

    task automatic test_stream_wrap();
        logic [7:0] d;
        sq.delete();
        b_ready_i = 3'h0; b_sel_i = 2'd0; b_valid_i = 1;
        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom);
            b_data_i = d;
            sq.push_back(d);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            b_data_i = d; b_valid_i = 1; b_ready_i = 3'b001;
            #1;
            checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, b_ready_o); end
            checks++; if (b_valid_o !== 3'b001) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 001", k, b_valid_o); end
            checks++; if (b_data_o !== {16'h0, sq[0]}) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, b_data_o, {16'h0, sq[0]}); end
            void'(sq.pop_front());
            sq.push_back(d);
            tick();
        end
        b_valid_i = 0;
        while (sq.size() != 0) begin
            b_ready_i = 3'b001;
            #1;
            checks++; if (b_data_o[7:0] !== sq[0]) begin errors++; $display("FAIL stream_drain: got %h expected %h", b_data_o[7:0], sq[0]); end
            void'(sq.pop_front());
            tick();
        end
        b_ready_i = 3'h0;
        checks++; if (b_valid_o !== 3'h0) begin errors++; $display("FAIL stream_empty: got %b expected 000", b_valid_o); end
        $display("test_stream_wrap done");
    endtask

    task automatic test_reset_mid();
        a_ready_i = 4'h0; a_valid_i = 1; a_sel_i = 2'd1; a_data_i = 8'h5A;
        tick();
        a_data_i = 8'h6B;
        tick();
        a_valid_i = 0;
        checks++; if (a_valid_o !== 4'b0010) begin errors++; $display("FAIL rstmid_filled: got %b expected 0010", a_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0000", a_valid_o); end
        checks++; if (a_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", a_data_o); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", a_ready_o); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b expected 1", a_ready_o); end
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL rstmid_valid_after: got %b expected 0000", a_valid_o); end
        a_valid_i = 1; a_data_i = 8'h7C;
        tick();
        a_valid_i = 0; a_ready_i = 4'b0010;
        checks++; if (a_data_o !== 32'h0000_7C00) begin errors++; $display("FAIL rstmid_fresh: got %h expected 00007c00", a_data_o); end
        tick();
        a_ready_i = 4'h0;
        checks++; if (a_valid_o !== 4'h0) begin errors++; $display("FAIL rstmid_pop: got %b expected 0000", a_valid_o); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic       exp_v, exp_r;
        logic [7:0] exp_d;
        int         pushes = 0;
        int         pops = 0;
        for (int ch = 0; ch < 4; ch++) mq[ch].delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                exp_v = (mq[ch].size() != 0);
                exp_d = exp_v ? mq[ch][0] : 8'h00;
                checks++; if (a_valid_o[ch] !== exp_v) begin errors++; $display("FAIL rand_valid c%0d ch%0d: got %b expected %b", cyc, ch, a_valid_o[ch], exp_v); end
                checks++; if (a_data_o[ch*8 +: 8] !== exp_d) begin errors++; $display("FAIL rand_data c%0d ch%0d: got %h expected %h", cyc, ch, a_data_o[ch*8 +: 8], exp_d); end
            end
            a_valid_i = ($urandom_range(0, 3) != 0);
            a_sel_i   = 2'($urandom_range(0, 3));
            a_data_i  = 8'($urandom);
            for (int ch = 0; ch < 4; ch++) a_ready_i[ch] = ($urandom_range(0, 9) < 4);
            #1;
            exp_r = (mq[a_sel_i].size() < 2);
            checks++; if (a_ready_o !== exp_r) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, a_ready_o, exp_r); end
            checks++; if (a_sel_err_o !== 1'b0) begin errors++; $display("FAIL rand_sel_err c%0d: got %b expected 0", cyc, a_sel_err_o); end
            for (int ch = 0; ch < 4; ch++) begin
                if (a_ready_i[ch] && mq[ch].size() != 0) begin
                    void'(mq[ch].pop_front());
                    pops++;
                end
            end
            if (a_valid_i && exp_r) begin
                mq[a_sel_i].push_back(a_data_i);
                pushes++;
            end
            tick();
        end
        a_valid_i = 0; a_ready_i = 4'h0;
        $display("test_random done: %0d pushes, %0d pops", pushes, pops);
    endtask

    initial begin
        test_reset();
        test_order();
        test_illegal_binary();
        test_onehot();
        test_stream_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
